inst_rom: RTL and testbench

Instruction memory that answers the PC register's fetch requests. Each cycle the PC register drives a byte address and a chip enable. This block returns the addressed 32-bit instruction word after a fixed, configurable number of cycles, with a valid strobe and an error flag. A word-wide load port lets the bench or boot logic fill the array. The block sits between the PC register and the IF/ID pipeline register.

---
 rtl/inst_rom_if.sv | 22 ++
 rtl/inst_rom.sv | 131 +++++++++++++
 tb/tb_inst_rom.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_if.sv
// Fetch and load-port bus between the PC register / boot logic (master) and inst_rom (slave).
interface inst_rom_if;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_err;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] fetch_cnt;

    modport master (
        output ce, addr, we, waddr, wdata,
        input  inst, inst_valid, inst_err, fetch_cnt
    );

    modport slave (
        input  ce, addr, we, waddr, wdata,
        output inst, inst_valid, inst_err, fetch_cnt
    );
endinterface

// File: rtl/inst_rom.sv
// Instruction memory with a LATENCY-edge fetch pipeline and a word-wide load port.
// Optional misaligned-fetch error enabled by defining INST_ROM_ALIGN_CHECK_EN.
module inst_rom #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    inst_rom_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int NST = (LATENCY > 1) ? (LATENCY - 1) : 1;

    typedef struct packed {
        logic          valid;
        logic          err;
        logic [AW-1:0] idx;
    } slot_t;

    function automatic logic in_range(input logic [31:0] byte_addr);
        in_range = ((byte_addr >> (AW + 2)) == 32'd0);
    endfunction

    logic [31:0] mem [DEPTH];

    slot_t       req_s;
    slot_t       rd_slot_s;
    logic        misalign_s;
    logic        wr_en_s;
    logic [31:0] inst_d;
    logic [31:0] inst_q;
    logic        valid_d;
    logic        valid_q;
    logic        err_d;
    logic        err_q;
    logic [31:0] cnt_d;
    logic [31:0] cnt_q;

    // Decode the incoming fetch into a pipeline slot; bubbles carry all-zero slots.
    always_comb begin
`ifdef INST_ROM_ALIGN_CHECK_EN
        misalign_s = (bus.addr[1:0] != 2'b00);
`else
        misalign_s = 1'b0;
`endif
        req_s.valid = bus.ce;
        req_s.err   = bus.ce & (~in_range(bus.addr) | misalign_s);
        if (bus.ce) begin
            req_s.idx = bus.addr[AW+1:2];
        end else begin
            req_s.idx = '0;
        end
    end

    generate
        if (LATENCY > 1) begin : g_pipe
            slot_t stage_d [NST];
            slot_t stage_q [NST];

            // Shift slots one stage per edge toward the array read.
            always_comb begin
                stage_d[0] = req_s;
                for (int i = 1; i < NST; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Stage registers; reset kills in-flight responses.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < NST; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < NST; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign rd_slot_s = stage_q[NST-1];
        end else begin : g_nopipe
            assign rd_slot_s = req_s;
        end
    endgenerate

    // Final-stage array read and fetch counter; the read sees pre-edge contents (read-first).
    always_comb begin
        valid_d = rd_slot_s.valid;
        err_d   = rd_slot_s.valid & rd_slot_s.err;
        if (rd_slot_s.valid && !rd_slot_s.err) begin
            inst_d = mem[rd_slot_s.idx];
        end else begin
            inst_d = 32'd0;
        end
        if (bus.ce) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign wr_en_s = bus.we & in_range(bus.waddr);

    // Load port; the array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[bus.waddr[AW+1:2]] <= bus.wdata;
        end
    end

    // Response and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_q  <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            inst_q  <= inst_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.inst       = inst_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst_err   = err_q;
    assign bus.fetch_cnt  = cnt_q;
endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom: three instances (LATENCY 1, 3, 4) share identical stimulus.
module tb_inst_rom;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    inst_rom_if b1 ();
    inst_rom_if b3 ();
    inst_rom_if b4 ();

    inst_rom #(.DEPTH(1024), .LATENCY(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    inst_rom #(.DEPTH(1024), .LATENCY(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));
    inst_rom #(.DEPTH(1024), .LATENCY(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        ce;
        logic [31:0] addr;
        logic        ev;
        logic        ee;
        logic [31:0] ei;
        logic [31:0] ecnt;
    } vec_t;

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic        ev;
        logic        ee;
        logic [31:0] ei;
    } seq_t;

    vec_t tv [18];
    seq_t sq [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic [31:0] addr,
                         input logic we, input logic [31:0] waddr, input logic [31:0] wdata);
        b1.ce = ce; b1.addr = addr; b1.we = we; b1.waddr = waddr; b1.wdata = wdata;
        b3.ce = ce; b3.addr = addr; b3.we = we; b3.waddr = waddr; b3.wdata = wdata;
        b4.ce = ce; b4.addr = addr; b4.we = we; b4.waddr = waddr; b4.wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic e, input logic [31:0] d,
                            input logic ev, input logic ee, input logic [31:0] ei);
        check({tag, "_valid"}, {31'd0, v}, {31'd0, ev});
        check({tag, "_err"},   {31'd0, e}, {31'd0, ee});
        check({tag, "_inst"},  d, ei);
    endtask

    logic        alerr;
    logic [31:0] alinst;
    int          j;
    logic        xv;
    logic        xe;
    logic [31:0] xi;

    initial begin
        tests = 0;
        fails = 0;
`ifdef INST_ROM_ALIGN_CHECK_EN
        alerr  = 1'b1;
        alinst = 32'h0000_0000;
`else
        alerr  = 1'b0;
        alinst = 32'h2222_2222;
`endif
        //        we    waddr         wdata          ce    addr          ev    ee     ei             cnt
        tv[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 32'h0,        1'b0, 1'b0,  32'h0,         32'd0};
        tv[1]  = '{1'b1, 32'h0000_0004, 32'h2222_2222, 1'b0, 32'h0,        1'b0, 1'b0,  32'h0,         32'd0};
        tv[2]  = '{1'b1, 32'h0000_0008, 32'h3333_3333, 1'b0, 32'h0,        1'b0, 1'b0,  32'h0,         32'd0};
        tv[3]  = '{1'b1, 32'h0000_000C, 32'h4444_4444, 1'b0, 32'h0,        1'b0, 1'b0,  32'h0,         32'd0};
        tv[4]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h1111_1111, 32'd1};
        tv[5]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h2222_2222, 32'd2};
        tv[6]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h3333_3333, 32'd3};
        tv[7]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'h4444_4444, 32'd4};
        tv[8]  = '{1'b0, 32'h0,         32'h0,         1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'd4};
        tv[9]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_1000, 1'b1, 1'b1, 32'h0,         32'd5};
        tv[10] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0006, 1'b1, alerr, alinst,       32'd6};
        tv[11] = '{1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h1111_1111, 32'd7};
        tv[12] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h1111_1111, 32'd8};
        tv[13] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'h2222_2222, 32'd9};
        tv[14] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd10};
        tv[15] = '{1'b1, 32'h0000_000B, 32'h5A5A_5A5A, 1'b0, 32'h0,        1'b0, 1'b0,  32'h0,         32'd10};
        tv[16] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h5A5A_5A5A, 32'd11};
        tv[17] = '{1'b0, 32'h0,         32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0,         32'd12};

        sq[0] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h1111_1111};
        sq[1] = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'hDEAD_BEEF};
        sq[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
        sq[3] = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'h3333_3333};
        sq[4] = '{1'b1, 32'h0000_2000, 1'b1, 1'b1, 32'h0};
        sq[5] = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'h4444_4444};

        // Reset state
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        #12;
        chk_resp("reset_l1", b1.inst_valid, b1.inst_err, b1.inst, 1'b0, 1'b0, 32'h0);
        check("reset_cnt", b1.fetch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: LATENCY=1 responses, counters on the accept edge
        for (int i = 0; i < 18; i++) begin
            drive(tv[i].ce, tv[i].addr, tv[i].we, tv[i].waddr, tv[i].wdata);
            step();
            chk_resp($sformatf("tv%0d_l1", i), b1.inst_valid, b1.inst_err, b1.inst,
                     tv[i].ev, tv[i].ee, tv[i].ei);
            check($sformatf("tv%0d_cnt_l1", i), b1.fetch_cnt, tv[i].ecnt);
            check($sformatf("tv%0d_cnt_l4", i), b4.fetch_cnt, tv[i].ecnt);
        end

        // Restore word 2 and drain the deeper pipelines
        drive(1'b0, 32'h0, 1'b1, 32'h0000_0008, 32'h3333_3333);
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step();

        // Streaming with a one-cycle gap, checked at each latency
        for (int t = 0; t < 9; t++) begin
            if (t < 6) drive(sq[t].ce, sq[t].addr, 1'b0, 32'h0, 32'h0);
            else       drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
            step();
            for (int l = 1; l <= 4; l++) begin
                if (l != 2) begin
                    j = t - (l - 1);
                    if (j >= 0 && j < 6) begin
                        xv = sq[j].ev; xe = sq[j].ee; xi = sq[j].ei;
                    end else begin
                        xv = 1'b0; xe = 1'b0; xi = 32'h0;
                    end
                    if (l == 1)
                        chk_resp($sformatf("seq%0d_l1", t), b1.inst_valid, b1.inst_err, b1.inst, xv, xe, xi);
                    else if (l == 3)
                        chk_resp($sformatf("seq%0d_l3", t), b3.inst_valid, b3.inst_err, b3.inst, xv, xe, xi);
                    else
                        chk_resp($sformatf("seq%0d_l4", t), b4.inst_valid, b4.inst_err, b4.inst, xv, xe, xi);
                end
            end
        end

        // Mid-flight reset: three fetches in flight on LATENCY=4
        drive(1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
        step();
        drive(1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0);
        step();
        drive(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0);
        step();
        chk_resp("pre_rst_l1", b1.inst_valid, b1.inst_err, b1.inst, 1'b1, 1'b0, 32'h3333_3333);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        chk_resp("rst_async_l1", b1.inst_valid, b1.inst_err, b1.inst, 1'b0, 1'b0, 32'h0);
        check("rst_async_cnt_l1", b1.fetch_cnt, 32'd0);
        check("rst_async_cnt_l4", b4.fetch_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("post_rst%0d_l4_valid", i), {31'd0, b4.inst_valid}, 32'd0);
            check($sformatf("post_rst%0d_l3_valid", i), {31'd0, b3.inst_valid}, 32'd0);
        end
        drive(1'b1, 32'h0000_0004, 1'b0, 32'h0, 32'h0);
        step();
        check("refetch_cnt_l4", b4.fetch_cnt, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("refetch_wait%0d_l4", i), {31'd0, b4.inst_valid}, 32'd0);
            step();
        end
        check("refetch_wait2_l4", {31'd0, b4.inst_valid}, 32'd0);
        step();
        chk_resp("refetch_l4", b4.inst_valid, b4.inst_err, b4.inst, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step();
        check("refetch_after_l4", {31'd0, b4.inst_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
